// File: rtl/mem_access_master.sv
// Initiator for the unified Memory port: one load/store at a time, LATENCY wait states per access,
// registered read data, response handshake and completed-access counters.
module mem_access_master #(
    parameter int unsigned LATENCY = 1  // wait-state cycles per access, 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr,
    output logic [31:0] din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] dout,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    req_t        req_q;
    logic [3:0]  wait_cnt;
    logic        misaligned;
    logic        last_wait;

    assign misaligned = (req_addr[1:0] != 2'b00);
    assign last_wait  = (state == S_WAIT) && (wait_cnt == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = misaligned ? S_RESP : S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from state so an async reset drops them immediately;
    // a store writes only on the final wait edge, giving exactly one write.
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign mem_read   = (state == S_WAIT) && !req_q.write;
    assign mem_write  = last_wait && req_q.write;
    assign addr       = req_q.addr;
    assign din        = req_q.wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q      <= '0;
            wait_cnt   <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            rd_count   <= 32'd0;
            wr_count   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_q.write <= req_write;
                        req_q.addr  <= req_addr;
                        req_q.wdata <= req_wdata;
                        resp_rdata  <= 32'd0;
                        resp_err    <= misaligned;
                        wait_cnt    <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        if (req_q.write) begin
                            wr_count <= wr_count + 32'd1;
                        end else begin
                            rd_count   <= rd_count + 32'd1;
                            resp_rdata <= dout;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench: two masters (LATENCY 1 and 3), each with its own behavioural memory.
module tb_mem_access_master;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [1:0]       mem_read, mem_write;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata, addr, din, dout, rd_count, wr_count;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [2][256];
    int          exp_rd[2];
    int          exp_wr[2];
    int          rstb[2];
    int          wstb[2];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [31:0] init_word(int k);
        return (k == 4) ? 32'hDEADBEEF : (32'hA5A5_0000 | 32'(k));
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_dut
        logic [31:0] mem [256];
        mem_access_master #(.LATENCY(i == 0 ? 1 : 3)) dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[i]),
            .req_ready  (req_ready[i]),
            .req_write  (req_write[i]),
            .req_addr   (req_addr[i]),
            .req_wdata  (req_wdata[i]),
            .resp_valid (resp_valid[i]),
            .resp_ready (resp_ready[i]),
            .resp_rdata (resp_rdata[i]),
            .resp_err   (resp_err[i]),
            .addr       (addr[i]),
            .din        (din[i]),
            .mem_read   (mem_read[i]),
            .mem_write  (mem_write[i]),
            .dout       (dout[i]),
            .rd_count   (rd_count[i]),
            .wr_count   (wr_count[i])
        );
        assign dout[i] = mem[addr[i][9:2]];
        always @(posedge clk) if (mem_write[i]) mem[addr[i][9:2]] = din[i];
        initial for (int k = 0; k < 256; k++) mem[k] = init_word(k);
    end

    function automatic logic [31:0] mem_rd(int d, int idx);
        return (d == 0) ? g_dut[0].mem[idx] : g_dut[1].mem[idx];
    endfunction

    // strobe cycle counters, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_read[i])  rstb[i]++;
            if (mem_write[i]) wstb[i]++;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(int d, bit w, logic [31:0] a, logic [31:0] wd, int hold);
        int   n, r0, w0, er, ew;
        exp_t e, p;
        @(negedge clk);
        chk("req_ready", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = w;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        resp_ready[d] = (hold == 0);
        r0 = rstb[d];
        w0 = wstb[d];
        e.err   = (a[1:0] != 2'b00);
        e.rdata = (e.err || w) ? 32'd0 : ref_mem[d][a[9:2]];
        er = 0;
        ew = 0;
        if (!e.err) begin
            if (w) begin
                ref_mem[d][a[9:2]] = wd;
                exp_wr[d]++;
                ew = 1;
            end else begin
                exp_rd[d]++;
                er = lat(d);
            end
        end
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            req_valid[d] = 1'b0;
            n++;
        end while (!resp_valid[d] && n < 40);
        chk("gap", 32'(n), e.err ? 32'd1 : 32'(lat(d) + 1));
        p = sb.pop_front();
        chk("rdata", resp_rdata[d], p.rdata);
        chk("err", 32'(resp_err[d]), 32'(p.err));
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1'b1;
            req_write[d] = ~w;
            req_addr[d]  = a + 32'd4;
            @(negedge clk);
            chk("hold_vld", 32'(resp_valid[d]), 32'd1);
            chk("hold_rdata", resp_rdata[d], p.rdata);
            chk("hold_rdy", 32'(req_ready[d]), 32'd0);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        chk("resp_drop", 32'(resp_valid[d]), 32'd0);
        chk("rd_count", rd_count[d], 32'(exp_rd[d]));
        chk("wr_count", wr_count[d], 32'(exp_wr[d]));
        chk("rd_strobes", 32'(rstb[d] - r0), 32'(er));
        chk("wr_strobes", 32'(wstb[d] - w0), 32'(ew));
        if (w && !e.err) chk("mem_word", mem_rd(d, int'(a[9:2])), wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        int w0;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 256; k++) ref_mem[d][k] = init_word(k);
            exp_rd[d] = 0;
            exp_wr[d] = 0;
            rstb[d]   = 0;
            wstb[d]   = 0;
        end
        reset      = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = '1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_rdata", resp_rdata[d], 32'd0);
            chk("rst_err", 32'(resp_err[d]), 32'd0);
            chk("rst_addr", addr[d], 32'd0);
            chk("rst_din", din[d], 32'd0);
            chk("rst_strobes", 32'({mem_read[d], mem_write[d]}), 32'd0);
            chk("rst_counts", rd_count[d] | wr_count[d], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // misaligned load: error, no access, counters untouched
        xfer(0, 1'b0, 32'h0000_0022, 32'd0, 0);
        xfer(0, 1'b1, 32'h0000_0031, 32'h1111_2222, 0);
        // aligned load of preloaded word
        xfer(0, 1'b0, 32'h0000_0010, 32'd0, 0);
        // store then load back through the 3-cycle master
        xfer(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 0);
        xfer(1, 1'b0, 32'h0000_0020, 32'd0, 0);
        // response back-pressure with a competing request held on the bus
        xfer(0, 1'b0, 32'h0000_0030, 32'd0, 5);

        // reset during the second wait cycle of a store
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h0000_0040;
        req_wdata[1] = 32'hCAFE_F00D;
        w0 = wstb[1];
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("mid_wait_rd", 32'(mem_read[1]), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_mid_strobes", 32'({mem_read[1], mem_write[1]}), 32'd0);
        chk("rst_mid_ready", 32'(req_ready[1]), 32'd1);
        chk("rst_mid_vld", 32'(resp_valid[1]), 32'd0);
        chk("rst_mid_rd0", rd_count[0], 32'd0);
        chk("rst_mid_cnt1", rd_count[1] | wr_count[1], 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_rd[d] = 0;
            exp_wr[d] = 0;
        end
        @(negedge clk);
        chk("rst_mid_word", mem_rd(1, 16), ref_mem[1][16]);
        chk("rst_mid_wstb", 32'(wstb[1] - w0), 32'd0);

        // ten store/load pairs on each master
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 10; i++) begin
                xfer(d, 1'b1, 32'h0000_0080 + 32'(4 * i), $urandom, 0);
                xfer(d, 1'b0, 32'h0000_0080 + 32'(4 * i), 32'd0, 0);
            end
            chk("final_rd", rd_count[d], 32'd10);
            chk("final_wr", wr_count[d], 32'd10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
